// File: rtl/config_chain_reader.sv
// config_chain_reader
//   Readback end of the configuration shift chain. A readback drives the
//   chain shift enable for CHAIN_LENGTH cycles and samples the tail bit on
//   each of those edges. Samples are packed LSB-first into 16-bit words in
//   an internal buffer, and a bit-serial CRC-16-CCITT is kept alongside.
//
// Ports
//   clk, rst_n        clock, asynchronous active-low reset
//   start             level-sampled; accepted in IDLE or DONE
//   chain_tail        serial output of the last chain stage
//   shift_en          registered chain advance, high CHAIN_LENGTH cycles
//   busy              high while shifting or flushing the last partial word
//   done              sticky completion flag, cleared by the next start
//   bit_count         bits captured so far (saturates at CHAIN_LENGTH)
//   crc               running CRC-16 (poly 0x1021, init 0xFFFF, no final xor)
//   rd_addr/rd_data   buffer read port, one cycle latency, 0 beyond DEPTH
module config_chain_reader #(
  parameter int CHAIN_LENGTH = 6140,
  parameter int WORD_WIDTH   = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        chain_tail,
  output logic        shift_en,
  output logic        busy,
  output logic        done,
  output logic [14:0] bit_count,
  output logic [15:0] crc,
  input  logic [8:0]  rd_addr,
  output logic [15:0] rd_data
);

  localparam int          DEPTH    = (CHAIN_LENGTH + WORD_WIDTH - 1) / WORD_WIDTH;
  localparam int          PW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  // Last word only partially filled -> one FLUSH cycle is needed.
  localparam bit          PARTIAL  = (CHAIN_LENGTH % WORD_WIDTH) != 0;
  localparam logic [14:0] LAST_BIT = 15'(CHAIN_LENGTH - 1);
  localparam logic [14:0] CNT_MAX  = 15'(CHAIN_LENGTH);

  typedef enum logic [1:0] {IDLE, SHIFT, FLUSH, DONE} state_t;

  state_t          state_q, state_d;
  logic            shift_en_q, shift_en_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic [14:0]     bit_count_q, bit_count_d;
  logic [15:0]     crc_q, crc_d;
  logic [15:0]     pack_q, pack_d;
  logic [PW-1:0]   word_ptr_q, word_ptr_d;
  logic [15:0]     rd_data_q, rd_data_d;

  logic            wr_en;
  logic [15:0]     wr_data;
  logic [15:0]     tail_word;
  logic [PW-1:0]   rd_idx;
  logic            fb;

  logic [15:0]     mem [DEPTH];

  always_comb begin
    state_d     = state_q;
    shift_en_d  = shift_en_q;
    busy_d      = busy_q;
    done_d      = done_q;
    bit_count_d = bit_count_q;
    crc_d       = crc_q;
    pack_d      = pack_q;
    word_ptr_d  = word_ptr_q;
    wr_en       = 1'b0;
    wr_data     = pack_q;

    // Pack register with the current sample merged in at bit_count % 16.
    tail_word = pack_q | (16'(chain_tail) << bit_count_q[3:0]);
    fb        = crc_q[15] ^ chain_tail;

    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d     = SHIFT;
          shift_en_d  = 1'b1;
          busy_d      = 1'b1;
          done_d      = 1'b0;
          bit_count_d = '0;
          crc_d       = 16'hFFFF;
          pack_d      = '0;
          word_ptr_d  = '0;
        end else if (state_q == DONE) begin
          // done is registered off the DONE state, so it rises one edge
          // after entry; a start accepted on that edge keeps it low.
          done_d = 1'b1;
        end
      end

      SHIFT: begin
        pack_d = tail_word;
        crc_d  = {crc_q[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
        if (bit_count_q < CNT_MAX)
          bit_count_d = bit_count_q + 15'd1;
        if (bit_count_q[3:0] == 4'hF) begin
          wr_en      = 1'b1;
          wr_data    = tail_word;
          pack_d     = '0;
          word_ptr_d = word_ptr_q + PW'(1);
        end
        if (bit_count_q == LAST_BIT) begin
          shift_en_d = 1'b0;
          if (PARTIAL) begin
            state_d = FLUSH;
          end else begin
            state_d = DONE;
            busy_d  = 1'b0;
          end
        end
      end

      FLUSH: begin
        // Unfilled high bits of pack_q are already zero.
        wr_en   = 1'b1;
        wr_data = pack_q;
        state_d = DONE;
        busy_d  = 1'b0;
      end

      default: state_d = IDLE;
    endcase

    // Array read happens before any same-edge write lands, so a colliding
    // read returns the old word.
    rd_idx    = PW'(rd_addr);
    rd_data_d = (32'(rd_addr) < DEPTH) ? mem[rd_idx] : 16'h0000;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      shift_en_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      bit_count_q <= '0;
      crc_q       <= 16'hFFFF;
      pack_q      <= '0;
      word_ptr_q  <= '0;
      rd_data_q   <= '0;
    end else begin
      state_q     <= state_d;
      shift_en_q  <= shift_en_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      bit_count_q <= bit_count_d;
      crc_q       <= crc_d;
      pack_q      <= pack_d;
      word_ptr_q  <= word_ptr_d;
      rd_data_q   <= rd_data_d;
    end
  end

  // Buffer storage is not reset; contents after a reset are undefined.
  always_ff @(posedge clk) begin
    if (wr_en)
      mem[word_ptr_q] <= wr_data;
  end

  assign shift_en  = shift_en_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign bit_count = bit_count_q;
  assign crc       = crc_q;
  assign rd_data   = rd_data_q;

endmodule

// File: tb/tb_config_chain_reader.sv
// Directed bench for config_chain_reader: three instances (1, 32 and 6140
// bit chains) driven from bench-side chain models.
module tb_config_chain_reader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, rst_c;

  logic        start_a, tail_a, se_a, busy_a, done_a;
  logic [14:0] bc_a;
  logic [15:0] crc_a, rd_a;
  logic [8:0]  ra_a;

  logic        start_b, tail_b, se_b, busy_b, done_b;
  logic [14:0] bc_b;
  logic [15:0] crc_b, rd_b;
  logic [8:0]  ra_b;

  logic        start_c, tail_c, se_c, busy_c, done_c;
  logic [14:0] bc_c;
  logic [15:0] crc_c, rd_c;
  logic [8:0]  ra_c;

  config_chain_reader #(.CHAIN_LENGTH(1)) u_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .chain_tail(tail_a),
    .shift_en(se_a), .busy(busy_a), .done(done_a), .bit_count(bc_a),
    .crc(crc_a), .rd_addr(ra_a), .rd_data(rd_a));

  config_chain_reader #(.CHAIN_LENGTH(32)) u_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .chain_tail(tail_b),
    .shift_en(se_b), .busy(busy_b), .done(done_b), .bit_count(bc_b),
    .crc(crc_b), .rd_addr(ra_b), .rd_data(rd_b));

  config_chain_reader u_c (
    .clk(clk), .rst_n(rst_c), .start(start_c), .chain_tail(tail_c),
    .shift_en(se_c), .busy(busy_c), .done(done_c), .bit_count(bc_c),
    .crc(crc_c), .rd_addr(ra_c), .rd_data(rd_c));

  // Chain models: the tail shows bit k after k shifts.
  logic [31:0] pat_b;
  logic [4:0]  ptr_b;
  always @(posedge clk or negedge rst_n)
    if (!rst_n) ptr_b <= '0;
    else if (se_b) ptr_b <= ptr_b + 5'd1;
  assign tail_b = pat_b[ptr_b];

  logic [15:0] img [384];
  logic [12:0] ptr_c;
  always @(posedge clk or negedge rst_c)
    if (!rst_c) ptr_c <= '0;
    else if (se_c) ptr_c <= ptr_c + 13'd1;
  assign tail_c = (ptr_c < 13'd6140) ? img[ptr_c[12:4]][ptr_c[3:0]] : 1'b0;

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  function automatic logic [15:0] crc_step(input logic [15:0] c, input logic b);
    logic f;
    f = c[15] ^ b;
    return {c[14:0], 1'b0} ^ (f ? 16'h1021 : 16'h0000);
  endfunction

  function automatic logic done_of(input int w);
    case (w)
      0: return done_a;
      1: return done_b;
      default: return done_c;
    endcase
  endfunction

  function automatic logic se_of(input int w);
    case (w)
      0: return se_a;
      1: return se_b;
      default: return se_c;
    endcase
  endfunction

  task automatic set_start(input int w, input logic v);
    case (w)
      0: start_a = v;
      1: start_b = v;
      default: start_c = v;
    endcase
  endtask

  // One readback: lat = edges from the accepting edge until done is seen,
  // se_n = cycles with shift_en high. Bounded by limit.
  task automatic run(input int w, input int limit, output int lat, output int se_n);
    @(negedge clk); set_start(w, 1'b1);
    @(posedge clk);
    @(negedge clk); set_start(w, 1'b0);
    lat  = 0;
    se_n = int'(se_of(w));
    while (!done_of(w) && lat < limit) begin
      @(posedge clk); lat++;
      @(negedge clk); se_n += int'(se_of(w));
    end
  endtask

  task automatic rd(input int w, input logic [8:0] a, output logic [15:0] d);
    @(negedge clk);
    case (w)
      0: ra_a = a;
      1: ra_b = a;
      default: ra_c = a;
    endcase
    @(posedge clk);
    @(negedge clk);
    case (w)
      0: d = rd_a;
      1: d = rd_b;
      default: d = rd_c;
    endcase
  endtask

  initial begin
    int lat, se_n, cnt;
    logic [15:0] d, exp_crc;

    rst_n = 1'b0; rst_c = 1'b0;
    start_a = 0; start_b = 0; start_c = 0;
    tail_a = 0; ra_a = '0; ra_b = '0; ra_c = '0;
    pat_b = 32'h8000_0001;
    for (int i = 0; i < 384; i++) img[i] = 16'h0000;
    img[0] = 16'h00ff; img[5] = 16'h000f; img[100] = 16'h1ff8; img[383] = 16'h0fff;

    // Reset values
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_se", se_a, 0);
    chk("rst_busy", busy_a, 0);
    chk("rst_done", done_a, 0);
    chk("rst_bc", bc_a, 0);
    chk("rst_crc", crc_a, 16'hFFFF);
    chk("rst_rd", rd_a, 0);
    rst_n = 1'b1; rst_c = 1'b1;

    // Single bit, tail = 0
    tail_a = 1'b0;
    run(0, 20, lat, se_n);
    chk("a0_lat", lat, 3);
    chk("a0_se_cycles", se_n, 1);
    chk("a0_crc", crc_a, 16'hEFDF);
    chk("a0_bc", bc_a, 1);
    rd(0, 9'd0, d); chk("a0_buf0", d, 16'h0000);
    rd(0, 9'd1, d); chk("a0_oor", d, 16'h0000);

    // Single bit, tail = 1 (restart from DONE)
    tail_a = 1'b1;
    run(0, 20, lat, se_n);
    chk("a1_lat", lat, 3);
    chk("a1_crc", crc_a, 16'hFFFE);
    rd(0, 9'd0, d); chk("a1_buf0", d, 16'h0001);
    chk("a1_done_sticky", done_a, 1);

    // Word packing, 32 bits
    run(1, 100, lat, se_n);
    chk("b_lat", lat, 33);
    chk("b_se_cycles", se_n, 32);
    chk("b_bc", bc_b, 32);
    exp_crc = 16'hFFFF;
    for (int i = 0; i < 32; i++) exp_crc = crc_step(exp_crc, pat_b[i]);
    chk("b_crc", crc_b, exp_crc);
    rd(1, 9'd0, d); chk("b_buf0", d, 16'h0001);
    rd(1, 9'd1, d); chk("b_buf1", d, 16'h8000);

    // Read/write collision on word 1: all-zero image overwrites 0x8000
    pat_b = 32'h0;
    @(negedge clk); ra_b = 9'd1; start_b = 1'b1;
    @(posedge clk);
    @(negedge clk); start_b = 1'b0;
    repeat (31) @(posedge clk);
    @(negedge clk); chk("b_pre_collide", rd_b, 16'h8000);
    @(posedge clk);          // word 1 write edge
    @(negedge clk); chk("b_collide_old", rd_b, 16'h8000);
    @(posedge clk);
    @(negedge clk); chk("b_after_write", rd_b, 16'h0000);

    // start held high: ignored while busy, restarts right at DONE
    pat_b = 32'h8000_0001;
    cnt = 0;
    while (!done_b && cnt < 100) begin @(negedge clk); cnt++; end
    @(negedge clk); start_b = 1'b1;
    @(posedge clk);
    cnt = 0;
    for (int i = 0; i < 32; i++) begin
      @(negedge clk); cnt += int'(se_b);
      @(posedge clk);
    end
    @(negedge clk);
    chk("hold_se_cycles", cnt, 32);
    chk("hold_se_off", se_b, 0);
    chk("hold_busy_off", busy_b, 0);
    @(posedge clk);
    @(negedge clk);
    chk("hold_restart_se", se_b, 1);
    chk("hold_restart_done", done_b, 0);
    chk("hold_restart_bc", bc_b, 0);
    start_b = 1'b0;
    cnt = 0;
    while (!done_b && cnt < 100) begin @(posedge clk); @(negedge clk); cnt++; end
    chk("hold_final_done", done_b, 1);
    chk("hold_final_bc", bc_b, 32);

    // Reset mid-readback at bit_count 100
    @(negedge clk); start_c = 1'b1;
    @(posedge clk);
    @(negedge clk); start_c = 1'b0;
    cnt = 0;
    while (bc_c != 15'd100 && cnt < 300) begin @(posedge clk); @(negedge clk); cnt++; end
    chk("c_reach100", bc_c, 100);
    rst_c = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("c_rst_se", se_c, 0);
    chk("c_rst_busy", busy_c, 0);
    chk("c_rst_done", done_c, 0);
    chk("c_rst_bc", bc_c, 0);
    chk("c_rst_crc", crc_c, 16'hFFFF);
    rst_c = 1'b1;

    // Default loopback
    run(2, 7000, lat, se_n);
    chk("c_lat", lat, 6142);
    chk("c_se_cycles", se_n, 6140);
    chk("c_bc", bc_c, 6140);
    exp_crc = 16'hFFFF;
    for (int k = 0; k < 6140; k++) exp_crc = crc_step(exp_crc, img[k / 16][k % 16]);
    chk("c_crc", crc_c, exp_crc);
    for (int i = 0; i < 384; i++) begin
      rd(2, 9'(i), d);
      chk($sformatf("c_buf%0d", i), d, img[i]);
    end
    rd(2, 9'd400, d); chk("c_rd400", d, 16'h0000);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
